// File: rtl/dds_spi_ctrl_pkg.sv
// dds_spi_ctrl_pkg: FSM states and field widths shared with the DDS register-map logic
// S_IOUPD exists only when DDS_IOUPDATE_EN is defined.
package dds_spi_ctrl_pkg;
    localparam int INSTR_RW_BIT = 7;
    localparam int CMD_LEN_W = 4;
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
`ifdef DDS_IOUPDATE_EN
        S_GAP,
        S_IOUPD
`else
        S_GAP
`endif
    } state_t;
endpackage

// File: rtl/dds_spi_ctrl_if.sv
// dds_spi_ctrl_if: command/response handshake between the DDS register-update logic and the SPI sequencer
interface dds_spi_ctrl_if #(parameter int MAX_BYTES = 8);
    import dds_spi_ctrl_pkg::*;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_rw;
    logic [6:0]             cmd_addr;
    logic [CMD_LEN_W-1:0]   cmd_len;
    logic [MAX_BYTES*8-1:0] cmd_wdata;
    logic                   rsp_valid;
    logic [MAX_BYTES*8-1:0] rsp_rdata;
    logic                   busy;
    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_len, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, busy
    );
    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_len, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/dds_spi_ctrl_timer.sv
// dds_spi_ctrl_timer: loadable down-counter that parks at zero; times cs_n setup/hold/gap and io_update
module dds_spi_ctrl_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (!zero) cnt <= cnt - W'(1);
    assign zero = cnt == '0;
endmodule

// File: rtl/dds_spi_ctrl.sv
// dds_spi_ctrl: frames an instruction byte plus 0..MAX_BYTES data bytes per cs_n window over a byte SPI engine
// Define DDS_IOUPDATE_EN to pulse io_update for IOUPD_CYC cycles after the gap that follows each write.
module dds_spi_ctrl
    import dds_spi_ctrl_pkg::*;
#(
    parameter int MAX_BYTES    = 8,
    parameter int SPI_MODE     = 0,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2,
    parameter int CS_GAP_CYC   = 4,
    parameter int IOUPD_CYC    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dds_spi_ctrl_if.slave cmd,
    output logic          cs_n,
    output logic [7:0]    drv_send_data,
    output logic          drv_start,
    output logic          drv_next,
    output logic [1:0]    drv_mode,
    input  logic [7:0]    drv_rec_data,
    input  logic          drv_done,
    input  logic          drv_idle,
    output logic          io_update
);
    localparam int TW = 8;
    localparam logic [CMD_LEN_W:0] L1 = 1, L2 = 2;
    state_t                 state, state_nx;
    logic [7:0]             instr, wbyte;
    logic [CMD_LEN_W-1:0]   len, len_clamp;
    logic [CMD_LEN_W:0]     left;
    logic [MAX_BYTES*8-1:0] wdata;
    logic [TW-1:0]          tmr_val;
    logic                   accept, tmr_zero;
    assign accept = cmd.cmd_valid && cmd.cmd_ready;
    assign len_clamp = cmd.cmd_len > CMD_LEN_W'(MAX_BYTES) ? CMD_LEN_W'(MAX_BYTES) : cmd.cmd_len;
    // left counts bytes not yet done, so the next unsent data byte sits (left-2) bytes up from the bottom
    assign wbyte = 8'(wdata >> {left - L2, 3'b000});
    assign cmd.cmd_ready = state == S_IDLE;
    assign cmd.busy = state != S_IDLE;
    assign cs_n = !(state inside {S_SETUP, S_XFER, S_HOLD});
    assign drv_mode = 2'(SPI_MODE);
    assign drv_start = state == S_SETUP && tmr_zero && drv_idle;
    assign drv_next = state == S_XFER && left > L1;
    assign drv_send_data = state == S_SETUP ? instr : drv_next ? wbyte : 8'h00;
    assign tmr_val = state == S_IDLE ? TW'(CS_SETUP_CYC) :
                     state == S_XFER ? TW'(CS_HOLD_CYC - 1) :
                     state == S_HOLD ? TW'(CS_GAP_CYC - 1) : TW'(IOUPD_CYC - 1);
`ifdef DDS_IOUPDATE_EN
    assign io_update = state == S_IOUPD;
`else
    assign io_update = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = accept ? S_SETUP : S_IDLE;
            S_SETUP: state_nx = drv_start ? S_XFER : S_SETUP;
            S_XFER:  state_nx = drv_done && left == L1 ? S_HOLD : S_XFER;
            S_HOLD:  state_nx = tmr_zero ? S_GAP : S_HOLD;
`ifdef DDS_IOUPDATE_EN
            S_GAP:   state_nx = !tmr_zero ? S_GAP : instr[INSTR_RW_BIT] ? S_IDLE : S_IOUPD;
            S_IOUPD: state_nx = tmr_zero ? S_IDLE : S_IOUPD;
`else
            S_GAP:   state_nx = tmr_zero ? S_IDLE : S_GAP;
`endif
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= S_IDLE;
            instr         <= '0;
            len           <= '0;
            left          <= '0;
            wdata         <= '0;
            cmd.rsp_valid <= 1'b0;
            cmd.rsp_rdata <= '0;
        end else begin
            state         <= state_nx;
            cmd.rsp_valid <= state == S_HOLD && tmr_zero;
            if (accept) begin
                instr         <= {cmd.cmd_rw, cmd.cmd_addr};
                len           <= len_clamp;
                left          <= {1'b0, len_clamp} + L1;
                wdata         <= cmd.cmd_wdata;
                cmd.rsp_rdata <= '0;
            end else if (state == S_XFER && drv_done) begin
                left <= left - L1;
                if (instr[INSTR_RW_BIT] && left != {1'b0, len} + L1)
                    cmd.rsp_rdata <= {cmd.rsp_rdata[MAX_BYTES*8-9:0], drv_rec_data};
            end
        end
    dds_spi_ctrl_timer #(.W(TW)) u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state != state_nx),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );
endmodule
